// File: rtl/sort4_cmp_sequencer.sv
// sort4_cmp_sequencer: in-place bubble sort of a small register file using
// one shared magnitude comparator, one compare per clock. Entries are loaded
// through a write port, sorted on a start pulse, and read back through a
// combinational read port once the done pulse fires.
module sort4_cmp_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic             descending,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [7:0]       swap_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Highest pass number; a pass counter equal to this means the final pass.
  // It is also the last compare index of pass 0.
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(DEPTH - 2);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] j;
  logic [IDX_W-1:0] j_plus1;
  logic [IDX_W-1:0] pass;
  logic             pass_swapped;
  logic             order;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             do_swap;
  logic             last_j;
  logic             finish;

  assign j_plus1 = j + IDX_W'(1);
  assign last_j  = (j == (LAST_PASS - pass));

  // Fetch the adjacent pair mem[j], mem[j+1] that feeds the shared comparator.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (IDX_W'(i) == j)       op_a = mem[i];
      if (IDX_W'(i) == j_plus1) op_b = mem[i];
    end
  end

  // Combinational read port; out-of-range indices read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (IDX_W'(i) == rd_idx) rd_data = mem[i];
    end
  end

  // Next-state logic and swap decision. Equal operands never swap, which
  // keeps the sort stable. A pass ends the sort early when it saw no swap.
  always_comb begin
    next_state = state;
    do_swap    = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_SORT;
      end
      ST_SORT: begin
        do_swap = order ? (op_a < op_b) : (op_a > op_b);
        if (last_j && ((!pass_swapped && !do_swap) || (pass == LAST_PASS))) begin
          finish     = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Registered status flags, aligned with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_state == ST_SORT);
      done <= (next_state == ST_DONE);
    end
  end

  // Pass/index counters, per-pass swap flag, swap statistics and sort order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j            <= '0;
      pass         <= '0;
      pass_swapped <= 1'b0;
      swap_count   <= '0;
      order        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            j            <= '0;
            pass         <= '0;
            pass_swapped <= 1'b0;
            swap_count   <= '0;
            order        <= descending;
          end
        end
        ST_SORT: begin
          if (do_swap) begin
            pass_swapped <= 1'b1;
            if (swap_count != 8'hFF) swap_count <= swap_count + 8'd1;
          end
          if (last_j) begin
            if (!finish) begin
              pass         <= pass + IDX_W'(1);
              j            <= '0;
              pass_swapped <= 1'b0;
            end
          end else begin
            j <= j_plus1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Register file: host writes only in IDLE, the sequencer owns it in SORT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == ST_IDLE) begin
      if (wr_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (IDX_W'(i) == wr_idx) mem[i] <= wr_data;
        end
      end
    end else if (state == ST_SORT) begin
      if (do_swap) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (IDX_W'(i) == j)       mem[i] <= op_b;
          if (IDX_W'(i) == j_plus1) mem[i] <= op_a;
        end
      end
    end
  end

endmodule

// File: tb/tb_sort4_cmp_sequencer.sv
// Testbench for sort4_cmp_sequencer: table of load/sort vectors with a
// scoreboard of expected results, plus hand-written reset and index sequences.
module tb_sort4_cmp_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             descending;
  logic [IDX_W-1:0] rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic [7:0]       swap_count;

  typedef struct {
    string           name;
    logic [3:0][7:0] init;
    bit              desc;
    bit              same_wr;
    bit              inject;
    logic [3:0][7:0] exp_mem;
    int              exp_swaps;
    int              exp_cycles;
  } vec_t;

  typedef struct {
    string           name;
    logic [3:0][7:0] exp_mem;
    int              exp_swaps;
    int              exp_cycles;
  } sb_t;

  vec_t vecs [5];
  sb_t  sb [$];
  int   checks = 0;
  int   errors = 0;

  sort4_cmp_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .start      (start),
    .descending (descending),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .swap_count (swap_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0][7:0] pack4(input logic [7:0] e0, input logic [7:0] e1,
                                            input logic [7:0] e2, input logic [7:0] e3);
    logic [3:0][7:0] r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Read all entries back through the read port and compare.
  task automatic checkMem(input string name, input logic [3:0][7:0] exp);
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = IDX_W'(i);
      #1;
      checkOutput($sformatf("%s mem[%0d]", name, i), 32'(rd_data), 32'(exp[i]));
    end
  endtask

  // Load a vector, start the sort and push its expected result.
  task automatic applyStimulus(input int v);
    sb_t e;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_idx  = IDX_W'(i);
      wr_data = vecs[v].init[i];
    end
    @(negedge clk);
    wr_en      = vecs[v].same_wr;
    wr_idx     = IDX_W'(3);
    wr_data    = 8'h00;
    start      = 1'b1;
    descending = vecs[v].desc;
    e.name       = vecs[v].name;
    e.exp_mem    = vecs[v].exp_mem;
    e.exp_swaps  = vecs[v].exp_swaps;
    e.exp_cycles = vecs[v].exp_cycles;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  // Wait for done (bounded), then pop the scoreboard and compare everything.
  task automatic runSort(input int v);
    sb_t e;
    int  cycles;
    applyStimulus(v);
    checkOutput({vecs[v].name, " busy during sort"}, 32'(busy), 32'd1);
    cycles = 0;
    while (done !== 1'b1 && cycles < 50) begin
      @(negedge clk);
      cycles++;
      if (vecs[v].inject && cycles == 2) begin
        wr_en   = 1'b1;
        wr_idx  = IDX_W'(0);
        wr_data = 8'h11;
        start   = 1'b1;
      end
      if (cycles == 3) begin
        wr_en = 1'b0;
        start = 1'b0;
      end
    end
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected one entry", vecs[v].name);
      return;
    end
    e = sb.pop_front();
    checkOutput({e.name, " latency"}, 32'(cycles), 32'(e.exp_cycles));
    checkOutput({e.name, " busy at done"}, 32'(busy), 32'd0);
    checkOutput({e.name, " swap_count"}, 32'(swap_count), 32'(e.exp_swaps));
    if (vecs[v].inject) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({e.name, " done single cycle"}, 32'(done), 32'd0);
    checkOutput({e.name, " busy after done"}, 32'(busy), 32'd0);
    checkMem(e.name, e.exp_mem);
  endtask

  initial begin
    int done_seen;

    vecs[0] = '{"mixed_asc", pack4(8'h55, 8'hFF, 8'h00, 8'h80), 1'b0, 1'b0, 1'b0,
                pack4(8'h00, 8'h55, 8'h80, 8'hFF), 3, 6};
    vecs[1] = '{"sorted_asc", pack4(8'h01, 8'h02, 8'h7F, 8'h80), 1'b0, 1'b0, 1'b0,
                pack4(8'h01, 8'h02, 8'h7F, 8'h80), 0, 3};
    vecs[2] = '{"reverse_desc", pack4(8'h00, 8'h55, 8'hAA, 8'hFF), 1'b1, 1'b0, 1'b1,
                pack4(8'hFF, 8'hAA, 8'h55, 8'h00), 6, 6};
    vecs[3] = '{"all_equal", pack4(8'h55, 8'h55, 8'h55, 8'h55), 1'b0, 1'b0, 1'b0,
                pack4(8'h55, 8'h55, 8'h55, 8'h55), 0, 3};
    vecs[4] = '{"write_with_start", pack4(8'h10, 8'h20, 8'h30, 8'h40), 1'b0, 1'b1, 1'b0,
                pack4(8'h00, 8'h10, 8'h20, 8'h30), 3, 6};

    rst_n      = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = '0;
    wr_data    = '0;
    start      = 1'b0;
    descending = 1'b0;
    rd_idx     = '0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset swap_count", 32'(swap_count), 32'd0);
    checkMem("reset", pack4(8'h00, 8'h00, 8'h00, 8'h00));
    rst_n = 1'b1;

    // Table-driven sorts.
    for (int v = 0; v < 5; v++) runSort(v);

    // Out-of-range write and read are ignored / read as zero.
    @(negedge clk);
    wr_en   = 1'b1;
    wr_idx  = IDX_W'(5);
    wr_data = 8'hEE;
    @(negedge clk);
    wr_en  = 1'b0;
    rd_idx = IDX_W'(5);
    #1;
    checkOutput("rd idx5", 32'(rd_data), 32'd0);
    checkMem("after idx5 write", pack4(8'h00, 8'h10, 8'h20, 8'h30));

    // Reset two cycles into a sort: everything clears, no done pulse.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_idx  = IDX_W'(i);
      wr_data = (i == 0) ? 8'hFF : (i == 1) ? 8'hAA : (i == 2) ? 8'h55 : 8'h00;
    end
    @(negedge clk);
    wr_en      = 1'b0;
    start      = 1'b1;
    descending = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre-reset swap_count", 32'(swap_count), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("midsort reset busy", 32'(busy), 32'd0);
    checkOutput("midsort reset done", 32'(done), 32'd0);
    checkOutput("midsort reset swap_count", 32'(swap_count), 32'd0);
    checkMem("midsort reset", pack4(8'h00, 8'h00, 8'h00, 8'h00));
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checkOutput("no activity after reset", 32'(done_seen), 32'd0);

    // A fresh load and sort after reset release works normally.
    runSort(0);

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort4_cmp_sequencer.md
Name: sort4_cmp_sequencer

Overview:
- Sequencer that time-shares a single WIDTH-bit magnitude comparator (equal/greater/less) to bubble-sort a DEPTH-entry register file in place, one compare per clock.
- Entries are loaded through a write port and sorted on a start pulse. Completion is signalled by a one-cycle done pulse, with the sorted entries readable through a combinational read port.
- Sits between a host/loader and downstream consumers of ordered data, such as min/max selection or median pick.

Parameters:
WIDTH, 8, data width of each entry and of the comparator operands
DEPTH, 4, number of entries; legal range 2..16
IDX_W, 4, width of index ports; must satisfy 2^IDX_W >= DEPTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
wr_en  input  1  write strobe for the register file
wr_idx  input  IDX_W  write index
wr_data  input  WIDTH  write data
start  input  1  begin sort; sampled only in IDLE
descending  input  1  sort order, captured at start: 0 = ascending, 1 = descending
rd_idx  input  IDX_W  read index
rd_data  output  WIDTH  combinational mem[rd_idx]; 0 if rd_idx >= DEPTH
busy  output  1  high while state = SORT
done  output  1  registered one-cycle pulse at sort completion
swap_count  output  8  number of swaps in the last sort, saturating at 255

Behaviour:
- Reset (async, rst_n=0): all mem entries = 0, state = IDLE, busy = 0, done = 0, swap_count = 0, pass/index counters = 0, order register = 0. Takes effect immediately, including mid-sort; the sort is abandoned with no done pulse.
- States: IDLE, SORT, DONE.
- IDLE:
  - wr_en with wr_idx < DEPTH writes mem[wr_idx] at the edge. wr_idx >= DEPTH is ignored.
  - start = 1 at edge k: state -> SORT, j = 0, pass = 0, pass_swapped = 0, swap_count = 0, order = descending.
  - A write in the same cycle as start is applied before the first compare.
- SORT:
  - Each edge compares a = mem[j], b = mem[j+1] (unsigned).
  - Swap condition: greater when ascending, less when descending. Equal never swaps, so the sort is stable.
  - A swap exchanges the two entries at that edge, increments swap_count (saturating), and sets pass_swapped.
  - j runs 0 .. DEPTH-2-pass.
  - At the last j of a pass: if pass_swapped = 0 or pass = DEPTH-2, state -> DONE. Otherwise pass++, j = 0, pass_swapped = 0.
  - wr_en and start are ignored throughout SORT; mem is owned by the sequencer.
- DONE: done = 1 for exactly this cycle, busy = 0. The next edge returns to IDLE unconditionally. start in DONE is ignored.
- Latency: with n compares performed, done is high in cycle n after the start edge (compares at edges k+1..k+n, DONE entered at edge k+n).
  - Already-sorted input: n = DEPTH-1.
  - Worst case: n = DEPTH(DEPTH-1)/2, which is 6 for DEPTH = 4.
- rd_data is readable in every state. During SORT it shows intermediate contents; after done it shows the final order.
- busy is registered, asserted from edge k through edge k+n.

Test Plan:
- Load [0x55,0xFF,0x00,0x80], start, descending=0 -> 6 compares, done in cycle 6, mem=[0x00,0x55,0x80,0xFF], swap_count=3.
- Load [0x01,0x02,0x7F,0x80], ascending -> early exit after 3 compares, done in cycle 3, swap_count=0, contents unchanged.
- Load [0x00,0x55,0xAA,0xFF], descending=1 -> done in cycle 6, mem=[0xFF,0xAA,0x55,0x00], swap_count=6. Also drive wr_en/start mid-sort and confirm they are ignored.
- Load all 0x55 -> 3 compares, swap_count=0, done single-cycle, busy low afterwards.
- Start with wr_en (idx 3, 0x00) in the same cycle on [0x10,0x20,0x30,0x40] -> sorted [0x00,0x10,0x20,0x30], swap_count=3. Writes and reads at idx 5 -> write ignored, rd_data=0.
- Pull rst_n low two cycles into a sort of [0xFF,0xAA,0x55,0x00] -> immediately all outputs 0, mem zeroed, no done pulse. A new load+start after release sorts correctly.
